// File: rtl/nv_scan_chain_ctrl.sv
// Scan chain controller: serially loads a pattern into one mux-D scan chain,
// pulses a single capture cycle, then unloads the response into rsp_data.
module nv_scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rsp_data
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_UNLOAD  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [CHAIN_LEN-1:0] pat_r;
  logic [CHAIN_LEN-1:0] pat_s;
  logic                 scan_in_s;

  // Next-state, counter and pattern-latch logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pat_s   = pat_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
          cnt_s   = CNT_ZERO;
          pat_s   = pat_data;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_CAPTURE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        state_s = ST_UNLOAD;
        cnt_s   = CNT_ZERO;
      end
      ST_UNLOAD: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Tail-first serialisation: the first bit shifted in ends up in the tail flop
  always_comb begin
    if (state_s == ST_SHIFT) begin
      scan_in_s = pat_s[CNT_LAST - cnt_s];
    end else begin
      scan_in_s = 1'b0;
    end
  end

  // State, counter, pattern and registered chain-control outputs
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      pat_r   <= {CHAIN_LEN{1'b0}};
      scan_en <= 1'b0;
      scan_in <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pat_r   <= pat_s;
      scan_en <= (state_s == ST_SHIFT) || (state_s == ST_UNLOAD);
      scan_in <= scan_in_s;
      busy    <= (state_s != ST_IDLE);
      done    <= (state_s == ST_DONE);
    end
  end

  // Response capture: the tail emerges first, so fill from the top bit down
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rsp_data <= {CHAIN_LEN{1'b0}};
    end else if (state_r == ST_UNLOAD) begin
      rsp_data[CNT_LAST - cnt_r] <= scan_out;
    end else begin
      rsp_data <= rsp_data;
    end
  end

endmodule

// File: tb/tb_nv_scan_chain_ctrl.sv
// Bench for nv_scan_chain_ctrl: an 8-flop and a 2-flop behavioural scan chain
// whose capture is D = Q ^ mask, so the expected response is pattern ^ mask.
module tb_nv_scan_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, scan_out8, scan_en8, scan_in8, busy8, done8;
  logic [7:0] pat8, rsp8, mask8;
  logic       start2, scan_out2, scan_en2, scan_in2, busy2, done2;
  logic [1:0] pat2, rsp2, mask2;
  logic [7:0] chain8_r = 8'h00;
  logic [1:0] chain2_r = 2'b00;
  int n_chk  = 0;
  int n_pass = 0;

  nv_scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .start(start8),
    .pat_data(pat8), .scan_out(scan_out8), .scan_en(scan_en8),
    .scan_in(scan_in8), .busy(busy8), .done(done8), .rsp_data(rsp8)
  );

  nv_scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .start(start2),
    .pat_data(pat2), .scan_out(scan_out2), .scan_en(scan_en2),
    .scan_in(scan_in2), .busy(busy2), .done(done2), .rsp_data(rsp2)
  );

  // Mux-D scan flops: shift head->tail when SE=1, else capture D = Q ^ mask
  always @(posedge clk) begin
    chain8_r <= scan_en8 ? {chain8_r[6:0], scan_in8} : (chain8_r ^ mask8);
    chain2_r <= scan_en2 ? {chain2_r[0], scan_in2} : (chain2_r ^ mask2);
  end
  assign scan_out8 = chain8_r[7];
  assign scan_out2 = chain2_r[1];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One 8-bit transaction; cycle c is the c-th cycle after the accept edge
  task automatic run8(input logic [7:0] pat, input logic [7:0] mask,
                      input logic [31:0] smask, input bit keep, input int rst_at);
    logic [3:0] exp_v;
    bit seen;
    @(negedge clk);
    chk_val("idle8", {29'd0, busy8, done8, scan_en8}, 32'd0);
    mask8 = mask; pat8 = pat; start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0; start8 = 1'b0;
        #1;
        chk_val("rst_mid", {20'd0, scan_en8, scan_in8, busy8, done8, rsp8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done8 || busy8) seen = 1'b1;
        end
        chk_val("no_done_after_rst", {31'd0, seen}, 32'd0);
        return;
      end
      exp_v = {(c <= 8) || (c >= 10 && c <= 17), (c <= 8) ? pat[8 - c] : 1'b0, 1'b1, c == 18};
      chk_val($sformatf("cyc%0d", c), {28'd0, scan_en8, scan_in8, busy8, done8}, {28'd0, exp_v});
      if (c == 18) chk_val("rsp8", {24'd0, rsp8}, {24'd0, pat ^ mask});
      start8 = smask[c];
      pat8   = 8'($urandom);
    end
    if (!keep) begin
      @(negedge clk);
      start8 = 1'b0;
      chk_val("post8", {30'd0, busy8, done8}, 32'd0);
    end
  endtask

  task automatic run2(input logic [1:0] pat, input logic [1:0] mask);
    int done_c = 0;
    @(negedge clk);
    mask2 = mask; pat2 = pat; start2 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      pat2   = 2'($urandom);
      if (c <= 2) chk_val("sin2", {30'd0, scan_en2, scan_in2}, {30'd0, 1'b1, pat[2 - c]});
      if (done2 && done_c == 0) begin
        done_c = c;
        chk_val("rsp2", {30'd0, rsp2}, {30'd0, pat ^ mask});
      end
    end
    chk_val("done2_cyc", done_c, 32'd6);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; pat8 = 8'h00; mask8 = 8'h00;
    start2 = 1'b0; pat2 = 2'b00; mask2 = 2'b00;
    repeat (2) @(negedge clk);
    chk_val("rst8", {20'd0, scan_en8, scan_in8, busy8, done8, rsp8}, 32'd0);
    chk_val("rst2", {26'd0, scan_en2, scan_in2, busy2, done2, rsp2}, 32'd0);
    rst_n = 1'b1;

    run8(8'hA5, 8'hFF, 32'd0, 1'b0, 0);
    run8(8'h3C, 8'h00, 32'd0, 1'b0, 0);
    run8(8'($urandom), 8'hFF, 32'h0004_0008, 1'b0, 0);
    run8(8'hFF, 8'h00, 32'hFFFF_FFFF, 1'b1, 0);
    run8(8'hFF, 8'h00, 32'hFFFF_FFFF, 1'b0, 0);
    run8(8'($urandom), 8'hFF, 32'd0, 1'b0, 12);
    run8(8'($urandom), 8'hFF, 32'd0, 1'b0, 0);
    repeat (6) run8(8'($urandom), 8'($urandom), $urandom & 32'h0007_FFFE, 1'b0, 0);

    run2(2'b01, 2'b11);
    repeat (4) run2(2'($urandom), 2'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nv_scan_chain_ctrl.md
Name: nv_scan_chain_ctrl

Overview:
- Drives and unloads one scan chain built from the team's mux-D scan flops (SI/D/SE/CP, Q), per test request.
- Sequence: serially load a pattern into the chain, pulse one functional capture cycle, then serially shift the captured response back out and present it in parallel.
- Sits in the DFT/BIST wrapper between the test sequencer and the chain's SI/SE head and Q tail.

Parameters:
- CHAIN_LEN, 32, number of scan flops in the chain (>=2).
- CNT_W, $clog2(CHAIN_LEN), width of the internal shift counter.

Ports:
- nvdla_core_clk  input  1  single clock; chain flops share this clock.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- pat_data  input  CHAIN_LEN  pattern; bit i is loaded into chain flop i (flop 0 = head, flop CHAIN_LEN-1 = tail); latched on accept.
- scan_out  input  1  Q of the tail flop.
- scan_en  output  1  to all chain SE pins; 1 = shift, 0 = capture/functional.
- scan_in  output  1  to head flop SI.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse; rsp_data valid.
- rsp_data  output  CHAIN_LEN  captured response; bit i = value captured by flop i.

Behaviour:
- All outputs registered. Reset (async assert, sync deassert by the wrapper): state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, rsp_data=0, counter=0, pattern register=0.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: scan_en=0. On a clock edge with start=1, latch pat_data and go to SHIFT with counter=0.
- SHIFT, CHAIN_LEN cycles, k=0..CHAIN_LEN-1:
  - scan_en=1, scan_in=pat[CHAIN_LEN-1-k].
  - counter increments each cycle; on k=CHAIN_LEN-1 go to CAPTURE.
  - After the last edge, flop i holds pat[i].
- CAPTURE, 1 cycle: scan_en=0, scan_in=0; the chain captures its D inputs. Next state UNLOAD, counter=0.
- UNLOAD, CHAIN_LEN cycles, k=0..CHAIN_LEN-1:
  - scan_en=1, scan_in=0.
  - At the end-of-cycle edge, sample scan_out into rsp_data[CHAIN_LEN-1-k].
  - On k=CHAIN_LEN-1 go to DONE.
- DONE, 1 cycle: done=1, busy=1, scan_en=0. Next state IDLE.
- rsp_data holds until the next accepted start. It is not cleared at accept; it is overwritten bit-by-bit during UNLOAD.
- Latency: start accepted at edge t0 gives:
  - SHIFT cycles t0+1..t0+N
  - CAPTURE cycle t0+N+1
  - UNLOAD cycles t0+N+2..t0+2N+1
  - done in cycle t0+2N+2
- start while busy (SHIFT..DONE): ignored, no queuing. start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted, so back-to-back spacing is 2N+3 cycles.
- pat_data changes after accept have no effect.
- Counter wraps only via the explicit transition compare, never by overflow. CNT_W must represent CHAIN_LEN-1.
- Reset mid-operation: immediate return to reset values, scan_en drops to 0 asynchronously. Chain contents are undefined afterwards; no done pulse.
- scan_out X/unknown outside UNLOAD is never sampled.

Test Plan:
- CHAIN_LEN=8; bench chain of 8 scan flops with D_i=~Q_i. start with pat_data=8'hA5 → SHIFT drives scan_in sequence 1,0,1,0,0,1,0,1; done in cycle t0+18; rsp_data=8'h5A.
- Same bench, D_i=Q_i (hold), pat_data=8'h3C → rsp_data=8'h3C; scan_en=0 exactly in cycles t0+9 and t0+18.
- start pulsed at t0+3 and t0+18 after an accepted start → both ignored: single done pulse, busy continuous t0+1..t0+18.
- start held high continuously with D_i=Q_i, pat_data=8'hFF → second accept at edge t0+19, second done at t0+37, rsp_data=8'hFF both times.
- nvdla_core_rstn asserted during UNLOAD cycle t0+12 → scan_en, busy, done, rsp_data go to 0 immediately; no done after release; the next start completes normally.
- CHAIN_LEN=2 (minimum), D_i=~Q_i, pat_data=2'b01 → done in cycle t0+6, rsp_data=2'b10.
